// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// Receive buffer between the buart receiver and the j1 I/O read mux. Each byte
// that lands in the buart holding register is moved into a small FIFO, and the
// oldest stored byte is presented to the CPU until it is popped.
//
// Ports:
//   clk        system clock
//   resetq     asynchronous active-low reset
//   uart_valid buart holding register is full
//   uart_data  byte in the buart holding register
//   uart_rd    one-cycle pulse that empties the buart holding register
//   cpu_rd     CPU pop request for the head byte
//   clr_ovr    CPU request to clear the sticky overrun flag
//   cpu_data   byte at the FIFO head, zero when empty
//   cpu_valid  FIFO holds at least one byte
//   level      number of stored bytes, 0 to 2^DEPTH_LOG2
//   rx_irq     registered "level >= IRQ_LEVEL"
//   overrun    sticky, a byte was dropped because the FIFO was full
module uart_rx_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int IRQ_LEVEL  = 8
) (
  input  logic                  clk,
  input  logic                  resetq,
  input  logic                  uart_valid,
  input  logic [7:0]            uart_data,
  output logic                  uart_rd,
  input  logic                  cpu_rd,
  input  logic                  clr_ovr,
  output logic [7:0]            cpu_data,
  output logic                  cpu_valid,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  rx_irq,
  output logic                  overrun
);

  localparam int                  DEPTH      = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PTR_ONE    = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2:0] IRQ_THRESH = (DEPTH_LOG2 + 1)'(IRQ_LEVEL);

  typedef enum logic [1:0] {
    IDLE,
    ACK,
    SETTLE
  } state_e;

  state_e                state_q, state_d;
  logic [DEPTH_LOG2:0]   wptr_q, wptr_d;
  logic [DEPTH_LOG2:0]   rptr_q, rptr_d;
  logic                  uart_rd_q, uart_rd_d;
  logic                  rx_irq_q, rx_irq_d;
  logic                  overrun_q, overrun_d;
  logic [7:0]            mem_q [DEPTH];

  logic                  empty;
  logic                  full;
  logic                  ingest;
  logic                  push;
  logic                  discard;
  logic                  pop;

  // Pointers carry one extra wrap bit so that full and empty can be told
  // apart when the low (address) bits match.
  assign empty     = (wptr_q == rptr_q);
  assign full      = (wptr_q[DEPTH_LOG2-1:0] == rptr_q[DEPTH_LOG2-1:0]) &&
                     (wptr_q[DEPTH_LOG2] != rptr_q[DEPTH_LOG2]);
  assign level     = wptr_q - rptr_q;
  assign cpu_valid = !empty;
  assign cpu_data  = empty ? 8'd0 : mem_q[rptr_q[DEPTH_LOG2-1:0]];
  assign uart_rd   = uart_rd_q;
  assign rx_irq    = rx_irq_q;
  assign overrun   = overrun_q;

  // Ingest FSM state register. Reset returns to IDLE so a byte still waiting
  // in buart is picked up as soon as reset is released.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Ingest FSM next state. After a byte is taken we spend one cycle
  // acknowledging it and one more letting buart's valid flag fall, so the same
  // byte is never taken twice.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (uart_valid) state_d = ACK;
      ACK:     state_d = SETTLE;
      SETTLE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs and FIFO bookkeeping. The full test uses the pointers as they
  // stand before the edge, so a pop in the same cycle cannot make room for
  // the byte being pushed; that byte is dropped and flagged instead.
  always_comb begin
    ingest    = (state_q == IDLE) && uart_valid;
    push      = ingest && !full;
    discard   = ingest && full;
    pop       = cpu_rd && !empty;
    uart_rd_d = (state_d == ACK);
    wptr_d    = push ? (wptr_q + PTR_ONE) : wptr_q;
    rptr_d    = pop  ? (rptr_q + PTR_ONE) : rptr_q;
    rx_irq_d  = (level >= IRQ_THRESH);
    overrun_d = overrun_q;
    if (discard) begin
      overrun_d = 1'b1;
    end else if (clr_ovr) begin
      overrun_d = 1'b0;
    end
  end

  // Pointers and registered status outputs. Reset clears all of them so the
  // FIFO reads as empty regardless of what the storage array still holds.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      uart_rd_q <= 1'b0;
      rx_irq_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      uart_rd_q <= uart_rd_d;
      rx_irq_q  <= rx_irq_d;
      overrun_q <= overrun_d;
    end
  end

  // Byte storage. It is deliberately not reset; the pointers alone decide
  // which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q[DEPTH_LOG2-1:0]] <= uart_data;
    end
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive buffer between the `buart` receiver and the j1 I/O read mux. It drains each received byte from the UART's single holding register into a 2^DEPTH_LOG2-entry FIFO, then presents the oldest byte to the CPU at I/O address bit 12. The CPU pops it with `io_rd`. The block also exports a level, a threshold interrupt, and a sticky overrun flag, so Forth code can accept bursts longer than one character time.

## Interface

- `DEPTH_LOG2`, default 4: FIFO depth is 2^DEPTH_LOG2 bytes (16).
- `IRQ_LEVEL`, default 8: `rx_irq` asserts when the stored count is >= this value. Legal range is 1 to 2^DEPTH_LOG2.
- `clk` in 1: system clock (12 MHz oscillator).
- `resetq` in 1: asynchronous, active-low reset.
- `uart_valid` in 1: `buart` holding register is full.
- `uart_data` in 8: `buart` received byte, meaningful while `uart_valid`=1.
- `uart_rd` out 1: one-cycle pulse that clears the `buart` holding register (drives `buart` `rd`).
- `cpu_rd` in 1: pop request, equal to `io_rd & io_addr[12]`.
- `clr_ovr` in 1: clears `overrun`, equal to `io_wr & io_addr[13] & io_dout[8]`.
- `cpu_data` out 8: byte at the FIFO head; 8'd0 when empty.
- `cpu_valid` out 1: FIFO is non-empty (replaces `uart0_valid` in the flags word).
- `level` out DEPTH_LOG2+1: number of stored bytes, 0 to 2^DEPTH_LOG2.
- `rx_irq` out 1: registered, equals `level >= IRQ_LEVEL`.
- `overrun` out 1: sticky; a byte was discarded because the FIFO was full.

## Operation

- Storage: 2^DEPTH_LOG2 x 8 register array.
  - Write pointer and read pointer are each DEPTH_LOG2+1 bits wide; the MSB is the wrap bit.
  - Empty when the pointers are equal. Full when the low bits are equal and the MSBs differ.
  - `level` = wptr - rptr, computed modulo 2^(DEPTH_LOG2+1).
- Ingest FSM (states IDLE, ACK, SETTLE):
  - IDLE, `uart_valid`=1: if not full, write `uart_data` at wptr and increment wptr. If full, discard the byte and set `overrun`. In both cases go to ACK.
  - ACK: `uart_rd`=1 (registered output, high for exactly this one cycle). Go to SETTLE.
  - SETTLE: ignore `uart_valid`, which clears at the ACK edge inside `buart`. Go to IDLE.
  - IDLE, `uart_valid`=0: stay in IDLE.
  - The minimum spacing between two ingests is 3 cycles, far faster than one byte time at 115200 baud.
- CPU side:
  - `cpu_data` = mem[rptr] combinationally while non-empty; otherwise 8'd0.
  - `cpu_rd` while non-empty: increment rptr at the clock edge.
  - `cpu_rd` while empty: no pointer change and no error.
- Simultaneous push and pop in the same cycle:
  - Both happen.
  - `level` is unchanged.
  - When full, the pop frees no slot for that same cycle's push: the full test uses pre-edge pointers, so that byte is discarded and `overrun` is set.
- `overrun`:
  - Set by a discard.
  - Cleared by `clr_ovr`.
  - If a discard and `clr_ovr` occur in the same cycle, set wins.
- Reset (`resetq`=0, asynchronous):
  - Both pointers become 0, the FSM goes to IDLE, `uart_rd`=0, `rx_irq`=0, `overrun`=0.
  - Memory contents are not reset.
  - The outputs then read `cpu_valid`=0, `level`=0, `cpu_data`=0.
  - Reset asserted during ACK drops `uart_rd` immediately.
  - A byte pending in `buart` after reset is ingested normally once `resetq` rises.

## Timing

- `uart_valid` rises before edge N while in IDLE:
  - the byte is stored at edge N;
  - `cpu_valid`/`level` update after edge N;
  - `uart_rd` is high from edge N to edge N+1;
  - the FSM is back in IDLE after edge N+2.
- `cpu_data` is valid in the same cycle as `cpu_rd`, so the j1 samples the head byte before the pop edge.
- After a pop, the next byte appears on `cpu_data` immediately after the edge.
- `rx_irq` lags `level` by one cycle (registered).
- All outputs except `cpu_data`, `cpu_valid` and `level` are registered. Those three are decoded from registers only, with no input-to-output path.

## Test plan

- Reset, then one byte 0x41: hold `uart_valid` high until `uart_rd` pulses.
  - Expect `uart_rd` high for exactly 1 cycle.
  - Expect `level`=1, `cpu_valid`=1, `cpu_data`=0x41.
  - Then `cpu_rd` for 1 cycle: expect `level`=0 and `cpu_data`=0.
- Burst of 16 bytes 0x00..0x0F with no reads, then a 17th byte 0xAA.
  - Expect `level`=16 and `overrun`=1.
  - 16 pops return 0x00..0x0F in order; 0xAA is never seen.
  - `clr_ovr` then clears `overrun`.
- Pointer wrap: repeat 40 times: push 3 bytes, pop 3 bytes, with a running counter as data.
  - Expect byte order preserved and `level` returning to 0 each round across the wrap.
- Simultaneous push and pop at level 5: expect `level` to stay 5 and the head to advance by one.
  - Repeat at level 16: expect level 15 after the edge and `overrun`=1.
- `rx_irq` with the default `IRQ_LEVEL`=8: push 8 bytes; expect `rx_irq` high one cycle after `level` reaches 8. Pop 1; expect `rx_irq` low one cycle later.
- Reset mid-operation: assert `resetq`=0 during ACK with level 3.
  - Expect `uart_rd` low immediately and `level`=0 asynchronously.
  - Expect `cpu_rd` on empty to have no effect.
  - After release, a pending `uart_valid` is ingested with `level`=1.
